div_unit: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the EX stage beside the single-cycle ALU and takes the same forwarded operands A and B.
- Holds the pipeline through busy until it pulses done with a registered result.
- Special operand cases take a one-cycle fast path.

---
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the EX stage and div_unit.
//   start, op, A, B, flush : request side, driven by the pipeline (master)
//   result, busy, done,
//   ZeroFlag               : response side, driven by the divider (slave)
interface div_unit_if #(
   parameter int N = 32
);
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         flush;
   logic [N-1:0] result;
   logic         busy;
   logic         done;
   logic         ZeroFlag;

   modport master (
      output start, op, A, B, flush,
      input  result, busy, done, ZeroFlag
   );

   modport slave (
      input  start, op, A, B, flush,
      output result, busy, done, ZeroFlag
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus.start    request, accepted in IDLE or DONE when flush is low
//   bus.op       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   bus.A/B      dividend / divisor
//   bus.flush    pipeline kill, aborts any operation
//   bus.result   registered quotient or remainder
//   bus.busy     high while iterating
//   bus.done     one-cycle pulse when result is written
//   bus.ZeroFlag result == 0
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | one shift/subtract step per cycle, N cycles
// DONE   | result written this cycle, done high
module div_unit #(
   parameter int N = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic          rem_sel;
   logic          sign_q;
   logic          sign_r;
   logic [N-1:0]  quo;
   logic [N-1:0]  rem;
   logic [N-1:0]  b_mag;
   logic [N-1:0]  result_q;
   logic [CW-1:0] cnt;
   logic          done_q;

   logic          is_signed;
   logic [N-1:0]  a_mag_in;
   logic [N-1:0]  b_mag_in;
   logic          div_zero;
   logic          ovf;
   logic          take;
   logic [N-1:0]  fast_res;
   logic [N:0]    rem_sh;
   logic [N:0]    trial;
   logic [N-1:0]  quo_nx;
   logic [N-1:0]  rem_nx;
   logic [N-1:0]  calc_res;

   always_comb begin
      is_signed = ~bus.op[0];
      a_mag_in  = (is_signed && bus.A[N-1]) ? -bus.A : bus.A;
      b_mag_in  = (is_signed && bus.B[N-1]) ? -bus.B : bus.B;
      div_zero  = (bus.B == '0);
      ovf       = is_signed && (bus.A == {1'b1, {(N-1){1'b0}}}) && (bus.B == '1);
      take      = ((state == S_IDLE) || (state == S_DONE)) && bus.start && !bus.flush;

      fast_res = '0;
      if (div_zero) begin
         fast_res = bus.op[1] ? bus.A : '1;
      end else if (ovf) begin
         fast_res = bus.op[1] ? '0 : bus.A;
      end

      // Shifted partial remainder needs N+1 bits; a set MSB of the trial
      // difference means the subtraction went negative and is restored.
      rem_sh = {rem, quo[N-1]};
      trial  = rem_sh - {1'b0, b_mag};
      if (!trial[N]) begin
         rem_nx = trial[N-1:0];
         quo_nx = {quo[N-2:0], 1'b1};
      end else begin
         rem_nx = rem_sh[N-1:0];
         quo_nx = {quo[N-2:0], 1'b0};
      end

      if (rem_sel) begin
         calc_res = sign_r ? -rem_nx : rem_nx;
      end else begin
         calc_res = sign_q ? -quo_nx : quo_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         rem_sel  <= 1'b0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         quo      <= '0;
         rem      <= '0;
         b_mag    <= '0;
         result_q <= '0;
         cnt      <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (take) begin
                     rem_sel <= bus.op[1];
                     sign_q  <= is_signed & (bus.A[N-1] ^ bus.B[N-1]);
                     sign_r  <= is_signed & bus.A[N-1];
                     b_mag   <= b_mag_in;
                     if (div_zero || ovf) begin
                        result_q <= fast_res;
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                     end else begin
                        quo   <= a_mag_in;
                        rem   <= '0;
                        cnt   <= CW'(N - 1);
                        state <= S_CALC;
                     end
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_CALC: begin
                  quo <= quo_nx;
                  rem <= rem_nx;
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) begin
                     result_q <= calc_res;
                     done_q   <= 1'b1;
                     state    <= S_DONE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.result   = result_q;
   assign bus.busy     = (state == S_CALC);
   assign bus.done     = done_q;
   assign bus.ZeroFlag = (result_q == '0);
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit with a transaction-level reference
// model checked every cycle plus hand-computed per-operation expectations.
module tb_div_unit;
   localparam int N = 32;

   logic clk = 1'b0;
   logic rst;

   div_unit_if #(.N(N)) bus ();

   div_unit #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference arithmetic from the instruction semantics.
   function automatic logic [31:0] ref_div(input logic [1:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa, sb, sr;
      sa = a;
      sb = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         2'b00: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            sr = sa / sb;
            return sr;
         end
         2'b01: return a / b;
         2'b10: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            sr = sa % sb;
            return sr;
         end
         default: return a % b;
      endcase
   endfunction

   function automatic bit is_fast(input logic [1:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Transaction-level model: an accepted request either completes next
   // cycle (special operands) or after N busy cycles.
   int          m_left   = 0;
   bit          m_done   = 1'b0;
   logic [31:0] m_result = 32'd0;
   logic [31:0] m_pend   = 32'd0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left   = 0;
         m_done   = 1'b0;
         m_result = 32'd0;
      end else begin
         m_done = 1'b0;
         if (bus.flush) begin
            m_left = 0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done   = 1'b1;
               m_result = m_pend;
            end
         end else if (bus.start) begin
            m_pend = ref_div(bus.op, bus.A, bus.B);
            if (is_fast(bus.op, bus.A, bus.B)) begin
               m_done   = 1'b1;
               m_result = m_pend;
            end else begin
               m_left = N;
            end
         end
      end
   end

   always @(negedge clk) begin
      check(bus.busy == (m_left > 0), "cyc_busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
      check(bus.done == m_done, "cyc_done", {31'd0, bus.done}, {31'd0, m_done});
      check(bus.result == m_result, "cyc_result", bus.result, m_result);
      check(bus.ZeroFlag == (m_result == 32'd0), "cyc_zero",
            {31'd0, bus.ZeroFlag}, {31'd0, m_result == 32'd0});
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      #2;
      bus.start = 1'b1;
      bus.op    = o;
      bus.A     = a;
      bus.B     = b;
   endtask

   // Returns at the negedge where done is seen (start still as left).
   task automatic wait_done(input bit hold, output int lat, output int busy_cnt, output bit seen);
      lat = 0;
      busy_cnt = 0;
      seen = 1'b0;
      while (!seen && lat < 60) begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_cnt++;
         if (bus.done) seen = 1'b1;
         else begin
            #2 bus.start = hold;
         end
      end
   endtask

   task automatic drop_start();
      #2 bus.start = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input bit hold,
                         input string name);
      int lat, bc;
      bit seen;
      @(negedge clk);
      issue(o, a, b);
      wait_done(hold, lat, bc, seen);
      drop_start();
      check(seen, {name, "_done_seen"}, {31'd0, seen}, 32'd1);
      check(lat == exp_lat, {name, "_latency"}, lat, exp_lat);
      check(bc == exp_lat - 1, {name, "_busy_cycles"}, bc, exp_lat - 1);
      check(bus.result == exp, {name, "_result"}, bus.result, exp);
      check(bus.ZeroFlag == (exp == 32'd0), {name, "_zero"},
            {31'd0, bus.ZeroFlag}, {31'd0, exp == 32'd0});
   endtask

   initial begin
      int lat, bc, dcount;
      bit seen;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.A     = 32'd0;
      bus.B     = 32'd0;
      bus.flush = 1'b0;
      repeat (3) @(negedge clk);
      check(bus.busy == 1'b0, "reset_busy", {31'd0, bus.busy}, 32'd0);
      check(bus.done == 1'b0, "reset_done", {31'd0, bus.done}, 32'd0);
      check(bus.result == 32'd0, "reset_result", bus.result, 32'd0);
      check(bus.ZeroFlag == 1'b1, "reset_zero", {31'd0, bus.ZeroFlag}, 32'd1);
      #2 rst = 1'b0;

      run_op(2'b00, 32'd100,        32'd7, 32'd14,        33, 1'b0, "div_100_7");
      run_op(2'b00, 32'hFFFF_FF9C,  32'd7, 32'hFFFF_FFF2, 33, 1'b0, "div_m100_7");
      run_op(2'b10, 32'hFFFF_FF9C,  32'd7, 32'hFFFF_FFFE, 33, 1'b0, "rem_m100_7");
      run_op(2'b11, 32'd100,        32'd7, 32'd2,         33, 1'b0, "remu_100_7");
      run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFE,  33, 1'b0, "div_7_m3");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFD, 32'd1,          33, 1'b0, "rem_7_m3");
      run_op(2'b01, 32'd0,          32'd5, 32'd0,         33, 1'b0, "divu_0_5");
      run_op(2'b01, 32'hFFFF_FFFF,  32'd2, 32'h7FFF_FFFF, 33, 1'b0, "divu_max_2");

      // Flush at the 10th busy cycle: no done, result unchanged.
      @(negedge clk);
      issue(2'b00, 32'd100, 32'd7);
      repeat (10) begin
         @(negedge clk);
         #2 bus.start = 1'b0;
      end
      bus.flush = 1'b1;
      @(negedge clk);
      check(bus.busy == 1'b0, "flush_busy", {31'd0, bus.busy}, 32'd0);
      check(bus.done == 1'b0, "flush_done", {31'd0, bus.done}, 32'd0);
      check(bus.result == 32'h7FFF_FFFF, "flush_result", bus.result, 32'h7FFF_FFFF);
      #2 bus.flush = 1'b0;
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      check(dcount == 0, "flush_no_done", dcount, 0);

      run_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, "div_by_zero");
      run_op(2'b10, 32'd5, 32'd0, 32'd5,         1, 1'b0, "rem_by_zero");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1'b0, "rem_ovf");
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        33, 1'b0, "divu_no_ovf");
      run_op(2'b00, 32'd100, 32'd7, 32'd14, 33, 1'b0, "div_before_rst");

      // Async reset between edges in the middle of an operation.
      @(negedge clk);
      issue(2'b01, 32'd1000, 32'd3);
      repeat (5) begin
         @(negedge clk);
         #2 bus.start = 1'b0;
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check(bus.busy == 1'b0, "rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      check(bus.done == 1'b0, "rst_mid_done", {31'd0, bus.done}, 32'd0);
      check(bus.result == 32'd0, "rst_mid_result", bus.result, 32'd0);
      #1 rst = 1'b0;
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      check(dcount == 0, "rst_mid_no_done", dcount, 0);

      run_op(2'b00, 32'd100, 32'd7, 32'd14, 33, 1'b0, "div_after_rst");

      // start together with flush is dropped, even on a fast-path operand.
      @(negedge clk);
      issue(2'b00, 32'd5, 32'd0);
      bus.flush = 1'b1;
      @(negedge clk);
      check(bus.done == 1'b0, "start_flush_done", {31'd0, bus.done}, 32'd0);
      check(bus.busy == 1'b0, "start_flush_busy", {31'd0, bus.busy}, 32'd0);
      check(bus.result == 32'd14, "start_flush_result", bus.result, 32'd14);
      #2 bus.start = 1'b0;
      bus.flush = 1'b0;

      // Back-to-back: new request presented in the DONE cycle of the previous.
      @(negedge clk);
      issue(2'b00, 32'hFFFF_FF9C, 32'd7);
      wait_done(1'b0, lat, bc, seen);
      check(seen && lat == 33, "b2b_first_latency", lat, 33);
      check(bus.result == 32'hFFFF_FFF2, "b2b_first_result", bus.result, 32'hFFFF_FFF2);
      issue(2'b01, 32'd9, 32'd3);
      wait_done(1'b0, lat, bc, seen);
      drop_start();
      check(seen && lat == 33, "b2b_second_latency", lat, 33);
      check(bc == 32, "b2b_second_busy", bc, 32);
      check(bus.result == 32'd3, "b2b_second_result", bus.result, 32'd3);

      // start held through CALC: ignored, exactly one done.
      run_op(2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b1, "remu_hold_start");
      dcount = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      check(dcount == 0, "hold_single_done", dcount, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
